dmem_io: RTL and testbench
==========================

Name: dmem_io

Overview:
Data-side memory subsystem directly downstream of the single-cycle ARM core. It consumes the core's MemWrite, OPResult (address) and WriteData, and returns ReadData combinationally within the same cycle.
- Decodes a word-addressed data RAM plus a memory-mapped I/O page.
- The I/O page holds a free-running 32-bit timer and a FIFO-buffered 8N1 UART transmitter.
- All state updates occur on the rising clock edge.

Parameters:
RAM_WORDS, 64, data RAM depth in 32-bit words (power of two).
FIFO_DEPTH, 8, UART TX FIFO entries (power of two, >=2).
CLKS_PER_BIT, 16, clock cycles per UART bit (>=2).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
MemWrite  input  1  store strobe from core
OPResult  input  32  byte address from core ALU result
WriteData  input  32  store data from core
ReadData  output  32  load data to core, combinational
UartTx  output  1  serial TX line, idle high
TxIrq  output  1  high when TX FIFO empty and transmitter idle

Behaviour:
- Decode: I/O page when OPResult[31:8]==24'hFFFFFF; otherwise RAM. RAM index = OPResult[log2(RAM_WORDS)+1:2]; higher bits alias; OPResult[1:0] ignored (word access only).
- RAM: write on edge when MemWrite and RAM selected. Read is asynchronous, so a load in the cycle after a store returns the new word.
- I/O register map (offset = OPResult[7:0]):
  - 0x00 TXDATA: write pushes WriteData[7:0]; read returns 0.
  - 0x04 STATUS: read {28'b0, overflow, busy, full, empty}; write with WriteData[3]=1 clears overflow.
  - 0x08 TIMER: read returns current count; write loads WriteData.
  - Other offsets: read 0, writes ignored.
- Timer:
  - Increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A write takes priority over the increment: the written value is visible in the next cycle and increments from then on.
  - Reset value 0.
- TX FIFO (circular, head/tail pointers plus count):
  - Push when a TXDATA write occurs and count<FIFO_DEPTH at the start of the cycle.
  - A push into a full FIFO is dropped and sets the sticky overflow bit, even if a pop happens in the same cycle.
  - Pop only from a non-empty FIFO. A simultaneous push and pop leaves count unchanged.
  - If an overflow set and a STATUS clear occur in the same cycle, set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: UartTx=1. If FIFO non-empty, pop the head into the shift register and enter START.
  - START: UartTx=0 for CLKS_PER_BIT cycles.
  - DATA: shift 8 bits LSB first, CLKS_PER_BIT cycles each, with a 3-bit bit counter.
  - STOP: UartTx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back frames: STOP goes to IDLE, and IDLE pops in that same cycle, giving one extra idle-high cycle between frames.
  - busy = (state != IDLE). TxIrq = empty && !busy, registered-free (derived from state).
- Reset (also mid-frame), effective at the edge:
  - FSM goes to IDLE, UartTx=1.
  - FIFO count, pointers and overflow cleared; timer 0; bit and baud counters 0.
  - STATUS reads 0x1; TxIrq=1.
  - RAM contents are covered under Optional Feature.
- ReadData has no reset value of its own (purely combinational from the address). During reset it still reflects the decoded source.

Optional Feature:
Macro DMEM_HEXINIT_EN.
- Defined: RAM is preloaded at time 0 via $readmemh("data.hex"), and reset does not modify RAM.
- Undefined: no file load; reset synchronously clears every RAM word to 0.
- I/O behaviour is identical in both builds.

Test Plan:
- RAM store/load: after reset, store 0xDEADBEEF to 0x20, then the next-cycle load of 0x20 returns 0xDEADBEEF; a load of 0x20+4*RAM_WORDS (alias) also returns 0xDEADBEEF; a load of 0x24 returns 0 (macro undefined).
- Timer: release reset; a read of 0xFFFFFF08 10 cycles later returns 10. Write 0x100, then the reads in the following two cycles return 0x100 and 0x101. Loading 0xFFFFFFFF reads 0 the cycle after.
- UART frame (CLKS_PER_BIT=4): write 0xA5 to TXDATA.
  - UartTx sequence: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - busy is high for 40 cycles; TxIrq drops while busy and returns to 1 at the end.
- Overflow (FIFO_DEPTH=8): write bytes 0x00..0x09 on 10 consecutive cycles.
  - STATUS then reads overflow=1, full=1.
  - Exactly 0x00..0x08 are transmitted; 0x09 is lost.
  - Writing 0x8 to STATUS clears overflow.
- Reset mid-frame: assert reset during DATA for 1 cycle, with 3 bytes queued. Next cycle: UartTx=1, STATUS=0x1, TxIrq=1, and nothing further is transmitted.
- Unmapped I/O: a read of 0xFFFFFF0C returns 0; a write to 0xFFFFFF0C leaves RAM, timer and FIFO unchanged.

Source files
------------

// File: rtl/dmem_io.sv
// ============================================================================
// Module   : dmem_io
// Brief    : Data-side memory for the single-cycle core: word RAM plus an I/O
//            page with a free-running timer and a FIFO-buffered 8N1 UART TX.
//            Build option DMEM_HEXINIT_EN leaves RAM untouched by reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_io #(
    parameter int RAM_WORDS    = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] OPResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        UartTx,
    output logic        TxIrq
);

    localparam int c_AW = $clog2(RAM_WORDS);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_BW = $clog2(CLKS_PER_BIT);
    localparam logic [c_PW:0]   c_FULL      = (c_PW + 1)'(FIFO_DEPTH);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic            w_io_sel;
    logic [7:0]      w_offset;
    logic [c_AW-1:0] w_ram_idx;
    logic            w_ram_we;
    logic            w_txdata_wr;
    logic            w_status_wr;
    logic            w_timer_wr;

    assign w_io_sel    = (OPResult[31:8] == 24'hFFFFFF);
    assign w_offset    = OPResult[7:0];
    assign w_ram_idx   = OPResult[c_AW+1:2];
    assign w_ram_we    = MemWrite && !w_io_sel;
    assign w_txdata_wr = MemWrite && w_io_sel && (w_offset == 8'h00);
    assign w_status_wr = MemWrite && w_io_sel && (w_offset == 8'h04);
    assign w_timer_wr  = MemWrite && w_io_sel && (w_offset == 8'h08);

    // ------------------------------------------------------------------
    // Data RAM (asynchronous read)
    // ------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];

`ifdef DMEM_HEXINIT_EN
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                r_ram[i] <= '0;
            end
        end else if (w_ram_we) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Timer: a store overrides the increment for that cycle
    // ------------------------------------------------------------------
    logic [31:0] r_timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_timer_wr) begin
            r_timer <= WriteData;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_PW:0]   r_count;
    logic            r_ovf;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_push    = w_txdata_wr && !w_full;
    // Fullness is judged at the start of the cycle, so a same-cycle pop cannot rescue the push
    assign w_ovf_set = w_txdata_wr && w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_status_wr && WriteData[3]) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // UART transmit FSM
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic [2:0]      r_bit_cnt;
    logic [2:0]      w_bit_nxt;
    logic [c_BW-1:0] r_baud_cnt;
    logic [c_BW-1:0] w_baud_nxt;
    logic            w_tx;
    logic            w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_baud_cnt <= w_baud_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_baud_nxt  = r_baud_cnt;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        case (r_state)
            c_S_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_fifo[r_head];
                    w_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                w_tx = 1'b0;
                if (r_baud_cnt == c_BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = c_S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            c_S_DATA: begin
                w_tx = r_shift[0];
                if (r_baud_cnt == c_BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = c_S_STOP;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            c_S_STOP: begin
                if (r_baud_cnt == c_BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    assign w_busy = (r_state != c_S_IDLE);
    assign UartTx = w_tx;
    assign TxIrq  = w_empty && !w_busy;

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    always_comb begin
        ReadData = '0;
        if (w_io_sel) begin
            case (w_offset)
                8'h04:   ReadData = {28'b0, r_ovf, w_busy, w_full, w_empty};
                8'h08:   ReadData = r_timer;
                default: ReadData = '0;
            endcase
        end else begin
            ReadData = r_ram[w_ram_idx];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_io.sv
// ============================================================================
// Module   : tb_dmem_io
// Brief    : Directed self-checking bench for dmem_io (RAM, timer, UART TX).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_io;

    localparam int RAM_WORDS    = 64;
    localparam int FIFO_DEPTH   = 8;
    localparam int CLKS_PER_BIT = 4;

    localparam logic [31:0] c_TXDATA = 32'hFFFFFF00;
    localparam logic [31:0] c_STATUS = 32'hFFFFFF04;
    localparam logic [31:0] c_TIMER  = 32'hFFFFFF08;
    localparam logic [31:0] c_UNMAP  = 32'hFFFFFF0C;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] OPResult  = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        UartTx;
    logic        TxIrq;

    int checks = 0;
    int errors = 0;

    dmem_io #(
        .RAM_WORDS    (RAM_WORDS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .OPResult  (OPResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .UartTx    (UartTx),
        .TxIrq     (TxIrq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        OPResult  = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        OPResult = addr;
        #1;
        data = ReadData;
    endtask

    // Serial receiver: samples mid-bit, drops frames cut short by reset
    logic [7:0] rxq[$];
    logic       rst_seen = 1'b0;

    always @(posedge clk) begin
        if (reset) rst_seen = 1'b1;
    end

    initial begin
        logic [7:0] b;
        logic       start_ok;
        logic       stop_ok;
        forever begin
            @(negedge UartTx);
            rst_seen = 1'b0;
            repeat (CLKS_PER_BIT / 2) @(posedge clk);
            #1;
            start_ok = (UartTx == 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (CLKS_PER_BIT) @(posedge clk);
                #1;
                b[k] = UartTx;
            end
            repeat (CLKS_PER_BIT) @(posedge clk);
            #1;
            stop_ok = (UartTx == 1'b1);
            if (!rst_seen && start_ok && stop_ok) rxq.push_back(b);
        end
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  frame;
        logic        exp_bit;
        int          lows;

        // Reset state
        OPResult = c_STATUS;
        tick();
        tick();
        check("rst_status", ReadData, 32'h1);
        check("rst_uart", {31'b0, UartTx}, 32'h1);
        check("rst_irq", {31'b0, TxIrq}, 32'h1);

        // Timer
        reset = 1'b0;
        rd(c_TIMER, v);
        check("timer_start", v, 32'd0);
        repeat (10) tick();
        rd(c_TIMER, v);
        check("timer_10", v, 32'd10);
        store(c_TIMER, 32'h100);
        rd(c_TIMER, v);
        check("timer_load", v, 32'h100);
        tick();
        rd(c_TIMER, v);
        check("timer_load_inc", v, 32'h101);
        store(c_TIMER, 32'hFFFFFFFF);
        rd(c_TIMER, v);
        check("timer_max", v, 32'hFFFFFFFF);
        tick();
        rd(c_TIMER, v);
        check("timer_wrap", v, 32'h0);

        // RAM store/load and aliasing
        store(32'h20, 32'hDEADBEEF);
        rd(32'h20, v);
        check("ram_load", v, 32'hDEADBEEF);
        rd(32'h20 + 4 * RAM_WORDS, v);
        check("ram_alias", v, 32'hDEADBEEF);
        rd(32'h23, v);
        check("ram_byte_ofs", v, 32'hDEADBEEF);
        rd(32'h24, v);
        check("ram_neighbour", v, 32'h0);

        // Unmapped I/O offset
        rd(c_UNMAP, v);
        check("unmap_read", v, 32'h0);
        store(c_TIMER, 32'h500);
        store(c_UNMAP, 32'h55);
        rd(c_TIMER, v);
        check("unmap_timer", v, 32'h501);
        rd(32'h0C, v);
        check("unmap_ram3", v, 32'h0);
        rd(32'h20, v);
        check("unmap_ram20", v, 32'hDEADBEEF);
        rd(c_STATUS, v);
        check("unmap_status", v, 32'h1);

        // Single UART frame 0xA5
        rxq.delete();
        frame = 8'hA5;
        store(c_TXDATA, {24'h0, frame});
        rd(c_STATUS, v);
        check("push_status", v, 32'h0);
        check("push_irq", {31'b0, TxIrq}, 32'h0);
        tick();
        for (int i = 0; i < 40; i++) begin
            if (i < 4)        exp_bit = 1'b0;
            else if (i >= 36) exp_bit = 1'b1;
            else              exp_bit = frame[(i - 4) / 4];
            check($sformatf("frame_bit%0d", i), {31'b0, UartTx}, {31'b0, exp_bit});
            check($sformatf("frame_busy%0d", i), ReadData & 32'h4, 32'h4);
            check($sformatf("frame_irq%0d", i), {31'b0, TxIrq}, 32'h0);
            tick();
        end
        check("frame_end_irq", {31'b0, TxIrq}, 32'h1);
        check("frame_end_status", ReadData, 32'h1);
        check("frame_rx_count", rxq.size(), 32'd1);
        check("frame_rx_byte", (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'hFFFFFFFF, 32'hA5);

        // Overflow: ten back-to-back pushes
        rxq.delete();
        MemWrite = 1'b1;
        OPResult = c_TXDATA;
        for (int i = 0; i < 10; i++) begin
            WriteData = i;
            tick();
        end
        MemWrite = 1'b0;
        rd(c_STATUS, v);
        check("ovf_status", v, 32'hE);
        store(c_STATUS, 32'h8);
        rd(c_STATUS, v);
        check("ovf_cleared", v, 32'h6);
        for (int n = 0; n < 1000 && rxq.size() < 9; n++) tick();
        check("ovf_rx_count", rxq.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("ovf_rx%0d", i),
                  (rxq.size() > i) ? {24'h0, rxq[i]} : 32'hFFFFFFFF, i);
        end
        repeat (100) tick();
        check("ovf_rx_final", rxq.size(), 32'd9);
        rd(c_STATUS, v);
        check("ovf_idle_status", v, 32'h1);

        // Reset in the middle of a frame with three bytes queued
        MemWrite = 1'b1;
        OPResult = c_TXDATA;
        for (int i = 1; i <= 4; i++) begin
            WriteData = 32'h11 * i;
            tick();
        end
        MemWrite = 1'b0;
        repeat (8) tick();
        rd(c_STATUS, v);
        check("mid_busy", v, 32'h6 & 32'h4 | 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(c_STATUS, v);
        check("mid_rst_status", v, 32'h1);
        check("mid_rst_uart", {31'b0, UartTx}, 32'h1);
        check("mid_rst_irq", {31'b0, TxIrq}, 32'h1);
        rd(32'h20, v);
        check("mid_rst_ram", v, 32'h0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            if (UartTx !== 1'b1) lows++;
            tick();
        end
        check("mid_rst_line_lows", lows, 32'd0);
        check("mid_rst_rx_count", rxq.size(), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
